// File: rtl/rm_counter.sv
// rtl/rm_counter.sv - LDM/STM register-mask counter producing RM_CNTR_DONE
// Optional feature macro: RM_CNTR_PC_FLAG_EN (registers pc_in_list on load).
module rm_counter #(
    parameter int LIST_W = 16,
    parameter int ADDR_W = 32,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LIST_W-1:0] reglist,
    input  logic [ADDR_W-1:0] base,
    input  logic              p_bit,
    input  logic              u_bit,
    input  logic              step,
    output logic [3:0]        reg_num,
    output logic [ADDR_W-1:0] xfer_addr,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [4:0]        count,
    output logic              active,
    output logic              done,
    output logic              pc_in_list
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    state_t            state;
    logic [LIST_W-1:0] mask;
    logic [LIST_W-1:0] mask_next;
    logic [4:0]        load_cnt;
    logic [ADDR_W-1:0] load_off;
    logic [ADDR_W-1:0] load_start;
    logic [ADDR_W-1:0] load_wb;

    // Number of set bits; the transfer count for a list.
    function automatic logic [4:0] popcount(input logic [LIST_W-1:0] m);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < LIST_W; i++) begin
            if (m[i]) c = c + 5'd1;
        end
        return c;
    endfunction

    // Index of the lowest set bit; 0 when the list is empty.
    function automatic logic [3:0] lowest_bit(input logic [LIST_W-1:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // True when exactly one bit is set, i.e. the final transfer is on the bus.
    function automatic logic is_last(input logic [LIST_W-1:0] m);
        return (m != '0) && ((m & (m - 1'b1)) == '0);
    endfunction

    // Decode of the transfer being loaded: block size, start and writeback address.
    always_comb begin
        mask_next = mask & (mask - 1'b1);
        load_cnt  = popcount(reglist);
        load_off  = STRIDE_A * ADDR_W'(load_cnt);
        load_wb   = u_bit ? (base + load_off) : (base - load_off);
        case ({u_bit, p_bit})
            2'b10:   load_start = base;
            2'b11:   load_start = base + STRIDE_A;
            2'b00:   load_start = base - load_off + STRIDE_A;
            default: load_start = base - load_off;
        endcase
    end

    // Transfer sequencer: load captures a new list, step retires the lowest register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            xfer_addr <= '0;
            wb_addr   <= '0;
            count     <= 5'd0;
            reg_num   <= 4'd0;
            done      <= 1'b1;
        end else if (load) begin
            mask      <= reglist;
            count     <= load_cnt;
            xfer_addr <= load_start;
            wb_addr   <= load_wb;
            reg_num   <= lowest_bit(reglist);
            state     <= (reglist != '0) ? RUN : IDLE;
            done      <= (reglist == '0) || is_last(reglist);
        end else if (step && state == RUN) begin
            mask      <= mask_next;
            xfer_addr <= xfer_addr + STRIDE_A;
            if (mask_next == '0) begin
                state <= IDLE;
                done  <= 1'b1;
            end else begin
                reg_num <= lowest_bit(mask_next);
                done    <= is_last(mask_next);
            end
        end
    end

    assign active = (state == RUN);

`ifdef RM_CNTR_PC_FLAG_EN
    // Remember whether R15 is in the list so the sequencer can take the PC-reload path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_in_list <= 1'b0;
        end else if (load) begin
            pc_in_list <= reglist[LIST_W-1];
        end
    end
`else
    assign pc_in_list = 1'b0;
`endif

endmodule

// File: tb/tb_rm_counter.sv
// tb/tb_rm_counter.sv - directed self-checking bench for rm_counter
module tb_rm_counter;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] reglist;
    logic [31:0] base;
    logic        p_bit;
    logic        u_bit;
    logic        step;
    logic [3:0]  reg_num;
    logic [31:0] xfer_addr;
    logic [31:0] wb_addr;
    logic [4:0]  count;
    logic        active;
    logic        done;
    logic        pc_in_list;

    int errors = 0;
    int checks = 0;

    rm_counter dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .reglist    (reglist),
        .base       (base),
        .p_bit      (p_bit),
        .u_bit      (u_bit),
        .step       (step),
        .reg_num    (reg_num),
        .xfer_addr  (xfer_addr),
        .wb_addr    (wb_addr),
        .count      (count),
        .active     (active),
        .done       (done),
        .pc_in_list (pc_in_list)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] l, input logic [31:0] b,
                           input logic p, input logic u, input logic s);
        load = 1'b1; reglist = l; base = b; p_bit = p; u_bit = u; step = s;
        tick();
        load = 1'b0; step = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [3:0] r, input logic [31:0] a,
                        input logic d, input logic act);
        check({tag, ".reg"}, 32'(reg_num), 32'(r));
        check({tag, ".addr"}, xfer_addr, a);
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".active"}, 32'(active), 32'(act));
    endtask

    logic exp_pc;

    initial begin
        rst = 1'b1; load = 1'b0; reglist = '0; base = '0;
        p_bit = 1'b0; u_bit = 1'b0; step = 1'b0;
`ifdef RM_CNTR_PC_FLAG_EN
        exp_pc = 1'b1;
`else
        exp_pc = 1'b0;
`endif
        #12;
        xfer("rst", 4'd0, 32'h0, 1'b1, 1'b0);
        check("rst.count", 32'(count), 32'd0);
        check("rst.wb", wb_addr, 32'h0);
        check("rst.pc", 32'(pc_in_list), 32'd0);
        rst = 1'b0;
        tick();

        // IA, four registers
        do_load(16'h000F, 32'h1000, 1'b0, 1'b1, 1'b0);
        xfer("ia0", 4'd0, 32'h1000, 1'b0, 1'b1);
        check("ia.count", 32'(count), 32'd4);
        check("ia.wb", wb_addr, 32'h1010);
        step = 1'b1;
        tick(); xfer("ia1", 4'd1, 32'h1004, 1'b0, 1'b1);
        tick(); xfer("ia2", 4'd2, 32'h1008, 1'b0, 1'b1);
        tick(); xfer("ia3", 4'd3, 32'h100C, 1'b1, 1'b1);
        tick(); xfer("ia_end", 4'd3, 32'h1010, 1'b1, 1'b0);
        check("ia_end.wb", wb_addr, 32'h1010);
        check("ia_end.count", 32'(count), 32'd4);
        step = 1'b0;

        // DB, sparse list with R15
        do_load(16'h8001, 32'h2000, 1'b1, 1'b0, 1'b0);
        xfer("db0", 4'd0, 32'h1FF8, 1'b0, 1'b1);
        check("db.wb", wb_addr, 32'h1FF8);
        check("db.count", 32'(count), 32'd2);
        check("db.pc", 32'(pc_in_list), 32'(exp_pc));
        step = 1'b1;
        tick(); xfer("db1", 4'd15, 32'h1FFC, 1'b1, 1'b1);
        tick(); xfer("db_end", 4'd15, 32'h2000, 1'b1, 1'b0);
        step = 1'b0;

        // DA, three registers: start base-12+4
        do_load(16'h0124, 32'h5000, 1'b0, 1'b0, 1'b0);
        xfer("da0", 4'd2, 32'h4FF8, 1'b0, 1'b1);
        check("da.wb", wb_addr, 32'h4FF4);
        check("da.pc", 32'(pc_in_list), 32'd0);
        step = 1'b1;
        tick(); xfer("da1", 4'd5, 32'h4FFC, 1'b0, 1'b1);
        tick(); xfer("da2", 4'd8, 32'h5000, 1'b1, 1'b1);
        step = 1'b0;

        // Empty list, then an ignored step
        do_load(16'h0000, 32'h3000, 1'b0, 1'b1, 1'b0);
        xfer("empty", 4'd0, 32'h3000, 1'b1, 1'b0);
        check("empty.count", 32'(count), 32'd0);
        check("empty.wb", wb_addr, 32'h3000);
        step = 1'b1;
        tick(); xfer("empty_step", 4'd0, 32'h3000, 1'b1, 1'b0);
        check("empty_step.wb", wb_addr, 32'h3000);
        step = 1'b0;

        // Reload colliding with step
        do_load(16'h00F0, 32'h0100, 1'b0, 1'b1, 1'b0);
        xfer("rl0", 4'd4, 32'h0100, 1'b0, 1'b1);
        step = 1'b1;
        tick(); tick();
        xfer("rl2", 4'd6, 32'h0108, 1'b0, 1'b1);
        do_load(16'h0003, 32'h4000, 1'b0, 1'b1, 1'b1);
        xfer("coll", 4'd0, 32'h4000, 1'b0, 1'b1);
        check("coll.count", 32'(count), 32'd2);
        check("coll.wb", wb_addr, 32'h4008);

        // Async reset between edges during a full-list run
        do_load(16'hFFFF, 32'h8000, 1'b0, 1'b1, 1'b0);
        check("full.count", 32'(count), 32'd16);
        check("full.wb", wb_addr, 32'h8040);
        step = 1'b1;
        tick(); tick();
        xfer("full2", 4'd2, 32'h8008, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        xfer("arst", 4'd0, 32'h0, 1'b1, 1'b0);
        check("arst.count", 32'(count), 32'd0);
        check("arst.wb", wb_addr, 32'h0);
        rst = 1'b0;
        tick();
        xfer("arst_hold", 4'd0, 32'h0, 1'b1, 1'b0);
        step = 1'b0;

        // IB wrap-around at top of address space
        do_load(16'h0003, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
        xfer("wrap0", 4'd0, 32'hFFFF_FFFC, 1'b0, 1'b1);
        check("wrap.wb", wb_addr, 32'h0);
        step = 1'b1;
        tick(); xfer("wrap1", 4'd1, 32'h0000_0000, 1'b1, 1'b1);
        tick(); xfer("wrap_end", 4'd1, 32'h0000_0004, 1'b1, 1'b0);
        step = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
